// File: rtl/time_set_sequencer.sv
// time_set_sequencer
//   Takes a target hour/minute over a valid/ready port and drives the
//   digital_clock time-set switches (SW) to load it. The sequence is an hour
//   strobe, a one-cycle gap, then a minute strobe. After a settle period the
//   clock's readback is compared with the target. On a mismatch the load is
//   repeated up to MAX_RETRY times.
//
// Ports
//   clk        system clock
//   reset      asynchronous, active-low reset
//   req_valid  request valid
//   req_ready  request can be accepted (IDLE only)
//   req_hour   target hour, binary (0..23)
//   req_min    target minute, binary (0..59)
//   cur_hour   hour readback from digital_clock
//   cur_min    minute readback from digital_clock
//   sw_out     SW drive: [15] hour strobe, [14] minute strobe,
//              [10:6] hour data, [5:0] minute data
//   busy       request in progress
//   done       one-cycle pulse, load verified
//   err        one-cycle pulse, request rejected or retries exhausted
module time_set_sequencer #(
  parameter int unsigned HOLD_CYCLES   = 2,
  parameter int unsigned SETTLE_CYCLES = 2,
  parameter int unsigned MAX_RETRY     = 3
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [4:0]  req_hour,
  input  logic [5:0]  req_min,
  input  logic [4:0]  cur_hour,
  input  logic [5:0]  cur_min,
  output logic [15:0] sw_out,
  output logic        busy,
  output logic        done,
  output logic        err
);

  typedef enum logic [3:0] {
    IDLE, CHECK, LOAD_H, GAP1, LOAD_M, SETTLE, VERIFY, DONE, ERR
  } state_t;

  state_t      state, state_d;
  logic [3:0]  cnt;
  logic [2:0]  retry;
  logic        retry_inc;
  logic        regap;
  logic        armed;
  logic [4:0]  hour_q;
  logic [5:0]  min_q;

  logic        accept;
  logic        in_range;
  logic        min_wrap;
  logic [5:0]  nxt_min;
  logic [4:0]  nxt_hour;
  logic        match;

  // armed keeps req_ready low until the first edge after reset release.
  assign req_ready = (state == IDLE) && armed;
  assign accept    = req_valid && req_ready;
  assign in_range  = (hour_q <= 5'd23) && (min_q <= 6'd59);

  // Target plus one minute, so a natural clock tick during the load passes.
  assign min_wrap = (min_q == 6'd59);
  assign nxt_min  = min_wrap ? '0 : min_q + 6'd1;
  assign nxt_hour = min_wrap ? ((hour_q == 5'd23) ? '0 : hour_q + 5'd1) : hour_q;
  assign match    = ((cur_hour == hour_q)   && (cur_min == min_q)) ||
                    ((cur_hour == nxt_hour) && (cur_min == nxt_min));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state  <= IDLE;
      cnt    <= '0;
      retry  <= '0;
      regap  <= 1'b0;
      armed  <= 1'b0;
      hour_q <= '0;
      min_q  <= '0;
    end else begin
      armed <= 1'b1;
      state <= state_d;
      if (state_d != state) begin
        cnt <= '0;
      end else if (cnt != 4'hF) begin
        cnt <= cnt + 4'd1;
      end
      if (accept) begin
        hour_q <= req_hour;
        min_q  <= req_min;
      end
      if ((state == DONE) || (state == ERR)) begin
        retry <= '0;
      end else if (retry_inc) begin
        retry <= retry + 3'd1;
      end
      // GAP1 is shared: after a failed verify it leads back to LOAD_H,
      // otherwise (between the strobes) it leads on to LOAD_M.
      if (state == VERIFY) begin
        regap <= (state_d == GAP1);
      end else if (state == GAP1) begin
        regap <= 1'b0;
      end
    end
  end

  always_comb begin
    state_d   = state;
    retry_inc = 1'b0;
    unique case (state)
      IDLE:   if (accept) state_d = CHECK;
      CHECK:  state_d = in_range ? LOAD_H : ERR;
      LOAD_H: if (cnt == 4'(HOLD_CYCLES - 1)) state_d = GAP1;
      GAP1:   state_d = regap ? LOAD_H : LOAD_M;
      LOAD_M: if (cnt == 4'(HOLD_CYCLES - 1)) state_d = SETTLE;
      SETTLE: if (cnt == 4'(SETTLE_CYCLES - 1)) state_d = VERIFY;
      VERIFY: begin
        if (match) begin
          state_d = DONE;
        end else if (retry < 3'(MAX_RETRY)) begin
          state_d   = GAP1;
          retry_inc = 1'b1;
        end else begin
          state_d = ERR;
        end
      end
      DONE:   state_d = IDLE;
      ERR:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    sw_out = '0;
    // Data fields stay 0 for out-of-range requests so a rejected request
    // never presents anything on SW.
    if ((state != IDLE) && in_range) begin
      sw_out[10:6] = hour_q;
      sw_out[5:0]  = min_q;
    end
    sw_out[15] = (state == LOAD_H);
    sw_out[14] = (state == LOAD_M);
  end

  assign busy = (state != IDLE);
  assign done = (state == DONE);
  assign err  = (state == ERR);

endmodule

// File: tb/tb_time_set_sequencer.sv
module tb_time_set_sequencer;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid;
  logic        req_ready;
  logic [4:0]  req_hour;
  logic [5:0]  req_min;
  logic [4:0]  cur_hour;
  logic [5:0]  cur_min;
  logic [15:0] sw_out;
  logic        busy;
  logic        done;
  logic        err;

  time_set_sequencer #(
    .HOLD_CYCLES  (2),
    .SETTLE_CYCLES(2),
    .MAX_RETRY    (3)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .req_valid(req_valid),
    .req_ready(req_ready),
    .req_hour (req_hour),
    .req_min  (req_min),
    .cur_hour (cur_hour),
    .cur_min  (cur_min),
    .sw_out   (sw_out),
    .busy     (busy),
    .done     (done),
    .err      (err)
  );

  always #10 clk = ~clk;

  typedef struct {
    bit is_done;
    int lat;      // cycles from acceptance edge; -1 = not checked
  } exp_t;

  exp_t exp_q[$];
  int   acc_q[$];
  int   done_times[$];
  int   edge_n = 0;
  int   n_checks = 0;
  int   n_pass = 0;

  task automatic check(input string name, input int act, input int expv);
    n_checks++;
    if (act == expv) n_pass++;
    else $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at %0t",
                  name, act, act, expv, expv, $time);
  endtask

  always @(posedge clk) edge_n <= edge_n + 1;

  // Behavioural digital_clock: 0 = loads on strobes, 1 = stuck at 07:07,
  // 2 = loads and ticks one minute when the minute strobe drops.
  int         model_mode = 0;
  logic [4:0] m_hour;
  logic [5:0] m_min;
  logic       prev_m;
  assign cur_hour = m_hour;
  assign cur_min  = m_min;

  always @(posedge clk) begin
    if (!reset) begin
      m_hour <= '0;
      m_min  <= '0;
    end else if (model_mode == 1) begin
      m_hour <= 5'd7;
      m_min  <= 6'd7;
    end else begin
      if (sw_out[15]) m_hour <= sw_out[10:6];
      if (sw_out[14]) m_min  <= sw_out[5:0];
      if (model_mode == 2 && prev_m && !sw_out[14]) begin
        m_min <= (m_min == 6'd59) ? 6'd0 : m_min + 6'd1;
        if (m_min == 6'd59) m_hour <= (m_hour == 5'd23) ? 5'd0 : m_hour + 5'd1;
      end
    end
    prev_m <= sw_out[14];
  end

  // Monitor: records acceptances, pops the scoreboard on every done/err.
  always @(negedge clk) begin
    if (reset && req_valid && req_ready) acc_q.push_back(edge_n + 1);
    if (done || err) begin
      if (exp_q.size() == 0 || acc_q.size() == 0) begin
        check("unexpected_pulse", {30'd0, done, err}, 0);
      end else begin
        exp_t e;
        int   a;
        e = exp_q.pop_front();
        a = acc_q.pop_front();
        check("resp_kind_done", done, e.is_done);
        check("resp_kind_err", err, !e.is_done);
        if (e.lat >= 0) check("resp_latency", edge_n - a + 1, e.lat);
        if (done) done_times.push_back(edge_n);
      end
    end
  end

  task automatic send(input int h, input int m, input bit is_done, input int lat);
    exp_t e;
    e.is_done = is_done;
    e.lat     = lat;
    exp_q.push_back(e);
    @(posedge clk); #1;
    req_hour  = 5'(h);
    req_min   = 6'(m);
    req_valid = 1'b1;
    @(posedge clk); #1;
    req_valid = 1'b0;
  endtask

  task automatic drain(input int maxc);
    for (int i = 0; i < maxc; i++) begin
      if (exp_q.size() == 0 && !busy) break;
      @(negedge clk);
    end
    check("drain_timeout", exp_q.size(), 0);
  endtask

  function automatic logic [15:0] exp_sw(input int k, input int h, input int m);
    logic [15:0] v;
    v = '0;
    if (k >= 1 && k <= 10) v = 16'((h << 6) | m);
    if (k == 2 || k == 3) v = v | 16'h8000;
    if (k == 5 || k == 6) v = v | 16'h4000;
    return v;
  endfunction

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int hc, mc, ovl, viol, n_acc;
    bit ph, pm, saw_err;

    reset     = 1'b0;
    req_valid = 1'b0;
    req_hour  = '0;
    req_min   = '0;

    // Reset state
    repeat (3) @(negedge clk);
    check("rst_sw_out", sw_out, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_err", err, 0);
    check("rst_ready", req_ready, 0);
    reset = 1'b1;
    @(negedge clk);
    check("ready_after_release", req_ready, 1);

    // 10:45, first-try pass, cycle-accurate SW waveform
    model_mode = 0;
    send(10, 45, 1, 10);
    for (int k = 1; k <= 11; k++) begin
      @(negedge clk);
      check($sformatf("sw_1045_c%0d", k), sw_out, exp_sw(k, 10, 45));
      check($sformatf("busy_1045_c%0d", k), busy, (k <= 10) ? 1 : 0);
    end
    drain(50);

    // Out-of-range requests: err in cycle 2, SW untouched
    send(24, 0, 0, 2);
    for (int k = 1; k <= 3; k++) begin
      @(negedge clk);
      check($sformatf("sw_2400_c%0d", k), sw_out, 0);
    end
    drain(20);
    send(12, 60, 0, 2);
    for (int k = 1; k <= 3; k++) begin
      @(negedge clk);
      check($sformatf("sw_1260_c%0d", k), sw_out, 0);
    end
    drain(20);

    // 23:59 with a tick during SETTLE: readback 00:00 accepted, no retry
    model_mode = 2;
    send(23, 59, 1, 10);
    drain(50);
    model_mode = 0;

    // Clock ignores strobes: 4 loads then err
    model_mode = 1;
    hc = 0; mc = 0; ovl = 0; ph = 0; pm = 0; saw_err = 0;
    send(8, 15, 0, -1);
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (sw_out[15] && !ph) hc++;
      if (sw_out[14] && !pm) mc++;
      if (sw_out[15] && sw_out[14]) ovl++;
      ph = sw_out[15];
      pm = sw_out[14];
      if (err) begin
        saw_err = 1;
        break;
      end
    end
    check("stuck_err_seen", saw_err, 1);
    check("stuck_hour_strobes", hc, 4);
    check("stuck_min_strobes", mc, 4);
    check("stuck_overlap", ovl, 0);
    drain(20);
    model_mode = 0;

    // Reset during LOAD_M: outputs drop at once, nothing reported
    send(5, 30, 1, 10);
    repeat (5) @(negedge clk);
    check("mid_in_load_m", sw_out[14], 1);
    #2;
    reset = 1'b0;
    #1;
    check("mid_rst_sw_out", sw_out, 0);
    check("mid_rst_busy", busy, 0);
    exp_q.delete();
    acc_q.delete();
    repeat (2) @(negedge clk);
    reset = 1'b1;
    repeat (15) @(negedge clk);
    check("mid_ready_again", req_ready, 1);
    send(6, 0, 1, 10);
    drain(50);

    // Continuous req_valid: one acceptance per sequence, done every 11 cycles
    done_times.delete();
    n_acc = 0;
    viol  = 0;
    @(posedge clk); #1;
    req_hour  = 5'd1;
    req_min   = 6'd1;
    req_valid = 1'b1;
    for (int c = 0; c < 100 && n_acc < 3; c++) begin
      @(negedge clk);
      if (busy && req_ready) viol++;
      if (req_ready) begin
        exp_t e;
        e.is_done = 1;
        e.lat     = 10;
        exp_q.push_back(e);
        n_acc++;
      end
    end
    @(posedge clk); #1;
    req_valid = 1'b0;
    for (int i = 0; i < 60 && exp_q.size() != 0; i++) begin
      @(negedge clk);
      if (busy && req_ready) viol++;
    end
    check("cont_accepts", n_acc, 3);
    check("cont_ready_while_busy", viol, 0);
    check("cont_done_count", done_times.size(), 3);
    if (done_times.size() == 3) begin
      check("cont_spacing_1", done_times[1] - done_times[0], 11);
      check("cont_spacing_2", done_times[2] - done_times[1], 11);
    end
    repeat (5) @(negedge clk);
    check("cont_idle_end", busy, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
